// File: rtl/dcm_pkg.sv
// Shared types and constants for the down-counter sequence monitor.
// Used by down_count_monitor and its testbench.
package dcm_pkg;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] WRAP_VAL = 4'hF;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } dcm_state_e;

    // Predecessor of v on the 16-state down count; 0 wraps to 15.
    function automatic logic [CNT_W-1:0] dec_mod(input logic [CNT_W-1:0] v);
        return v - CNT_W'(1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
// Used for the wrap and error tallies of down_count_monitor.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/down_count_monitor.sv
// Checks that a 4-bit down counter steps by -1 mod 16, counts wraps and faults.
// Define DCM_ERR_LATCH_EN to latch the first fault (FAULT state) until clr or rst.
//
// state | meaning
// SYNC  | no reference value held; next valid sample is captured unchecked
// TRACK | reference held; each valid sample checked against last_cnt - 1
// FAULT | latched build only: mismatch seen, inputs ignored until clr/rst
module down_count_monitor
    import dcm_pkg::*;
#(
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic              cnt_vld,
    input  logic              clr,
    output logic              locked,
    output logic [CNT_W-1:0]  last_cnt,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              seq_err,
    output logic [ERR_W-1:0]  err_cnt
);

    dcm_state_e       state_q;
    logic [CNT_W-1:0] last_q;
    logic             wrap_pulse_q;
    logic             seq_err_q;

    logic match;
    logic is_wrap;
    logic check_en;
    logic wrap_inc;
    logic err_inc;

    assign match    = (cnt_in == dec_mod(last_q));
    assign is_wrap  = (last_q == '0) && (cnt_in == WRAP_VAL);
    assign check_en = !clr && cnt_vld && (state_q == TRACK);
    assign wrap_inc = check_en && match && is_wrap;
    assign err_inc  = check_en && !match;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= SYNC;
            last_q       <= '0;
            wrap_pulse_q <= 1'b0;
            seq_err_q    <= 1'b0;
        end else if (clr) begin
            state_q      <= SYNC;
            last_q       <= '0;
            wrap_pulse_q <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            wrap_pulse_q <= 1'b0;
`ifndef DCM_ERR_LATCH_EN
            seq_err_q    <= 1'b0;
`endif
            case (state_q)
                SYNC: begin
                    if (cnt_vld) begin
                        last_q  <= cnt_in;
                        state_q <= TRACK;
                    end
                end
                TRACK: begin
                    if (cnt_vld) begin
                        if (match) begin
                            last_q       <= cnt_in;
                            wrap_pulse_q <= is_wrap;
                        end else begin
                            seq_err_q <= 1'b1;
`ifdef DCM_ERR_LATCH_EN
                            state_q   <= FAULT;
`else
                            last_q    <= cnt_in;
`endif
                        end
                    end
                end
`ifdef DCM_ERR_LATCH_EN
                FAULT: begin
                    state_q <= FAULT;
                end
`endif
                default: begin
                    state_q <= SYNC;
                end
            endcase
        end
    end

    sat_counter #(.W(WRAP_W)) u_wrap_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (clr),
        .inc_i  (wrap_inc),
        .cnt_o  (wrap_cnt)
    );

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (clr),
        .inc_i  (err_inc),
        .cnt_o  (err_cnt)
    );

    assign locked     = (state_q == TRACK);
    assign last_cnt   = last_q;
    assign wrap_pulse = wrap_pulse_q;
    assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_down_count_monitor.sv
// Self-checking bench for down_count_monitor against an arithmetic reference model.
// Honours DCM_ERR_LATCH_EN the same way as the design.
module tb_down_count_monitor;

    logic       clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       rst = 1'b0;
    logic [3:0] cnt_in = 4'd0;
    logic       cnt_vld = 1'b0;
    logic       clr = 1'b0;
    logic       locked;
    logic [3:0] last_cnt;
    logic       wrap_pulse;
    logic [7:0] wrap_cnt;
    logic       seq_err;
    logic [3:0] err_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model state, in plain integers.
    bit m_has_ref, m_fault, m_seq_err, m_wrap_pulse;
    int m_last, m_wraps, m_errs;

    down_count_monitor #(.WRAP_W(8), .ERR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .cnt_vld    (cnt_vld),
        .clr        (clr),
        .locked     (locked),
        .last_cnt   (last_cnt),
        .wrap_pulse (wrap_pulse),
        .wrap_cnt   (wrap_cnt),
        .seq_err    (seq_err),
        .err_cnt    (err_cnt)
    );

    always #5 if (clk_en) clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic void model_reset();
        m_has_ref = 0; m_fault = 0; m_seq_err = 0; m_wrap_pulse = 0;
        m_last = 0; m_wraps = 0; m_errs = 0;
    endfunction

    function automatic void model_step(input bit c, input bit v, input int x);
        m_wrap_pulse = 0;
        if (c) begin
            model_reset();
            return;
        end
`ifndef DCM_ERR_LATCH_EN
        m_seq_err = 0;
`endif
        if (!v || m_fault) return;
        if (!m_has_ref) begin
            m_has_ref = 1;
            m_last = x;
        end else if (x == (m_last + 15) % 16) begin
            if (m_last == 0 && x == 15) begin
                m_wrap_pulse = 1;
                if (m_wraps < 255) m_wraps++;
            end
            m_last = x;
        end else begin
            m_seq_err = 1;
            if (m_errs < 15) m_errs++;
`ifdef DCM_ERR_LATCH_EN
            m_fault = 1;
`else
            m_last = x;
`endif
        end
    endfunction

    task automatic drive(input bit c, input bit v, input int x);
        @(negedge clk);
        clr = c; cnt_vld = v; cnt_in = x[3:0];
        @(posedge clk);
        #1;
        model_step(c, v, x);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        #12;
        checks++;
        if ({locked, last_cnt, wrap_pulse, wrap_cnt, seq_err, err_cnt} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0",
                     {locked, last_cnt, wrap_pulse, wrap_cnt, seq_err, err_cnt});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_sequence();
        int seq[$];
        int pulses = 0;
        seq.push_back(0);
        for (int v = 15; v >= 0; v--) seq.push_back(v);
        seq.push_back(15);
        foreach (seq[i]) begin
            drive(0, 1, seq[i]);
            if (wrap_pulse === 1'b1) pulses++;
            checks++;
            if (locked !== 1'b1 || last_cnt !== 4'(seq[i])) begin
                failures++;
                $display("FAIL seq_track i=%0d locked=%0b last=%0d exp_last=%0d", i, locked, last_cnt, seq[i]);
            end
            checks++;
            if (wrap_pulse !== m_wrap_pulse || seq_err !== 1'b0) begin
                failures++;
                $display("FAIL seq_flags i=%0d wrap_pulse=%0b exp=%0b seq_err=%0b", i, wrap_pulse, m_wrap_pulse, seq_err);
            end
        end
        checks++;
        if (pulses != 2 || wrap_cnt !== 8'd2 || err_cnt !== 4'd0) begin
            failures++;
            $display("FAIL seq_totals pulses=%0d wrap_cnt=%0d err_cnt=%0d exp=2/2/0", pulses, wrap_cnt, err_cnt);
        end
    endtask

    task automatic test_mismatch();
        drive(1, 0, 0);
        drive(0, 1, 9);
        drive(0, 1, 6);
        checks++;
        if (seq_err !== 1'b1 || err_cnt !== 4'd1) begin
            failures++;
            $display("FAIL mism_hit seq_err=%0b err_cnt=%0d exp=1/1", seq_err, err_cnt);
        end
`ifdef DCM_ERR_LATCH_EN
        checks++;
        if (locked !== 1'b0 || last_cnt !== 4'd9) begin
            failures++;
            $display("FAIL mism_latch locked=%0b last=%0d exp=0/9", locked, last_cnt);
        end
        drive(0, 1, 5);
        checks++;
        if (seq_err !== 1'b1 || last_cnt !== 4'd9 || err_cnt !== 4'd1 || locked !== 1'b0) begin
            failures++;
            $display("FAIL mism_hold seq_err=%0b last=%0d err=%0d locked=%0b exp=1/9/1/0", seq_err, last_cnt, err_cnt, locked);
        end
`else
        checks++;
        if (locked !== 1'b1 || last_cnt !== 4'd6) begin
            failures++;
            $display("FAIL mism_resync locked=%0b last=%0d exp=1/6", locked, last_cnt);
        end
        drive(0, 1, 5);
        checks++;
        if (seq_err !== 1'b0 || last_cnt !== 4'd5 || err_cnt !== 4'd1) begin
            failures++;
            $display("FAIL mism_next seq_err=%0b last=%0d err=%0d exp=0/5/1", seq_err, last_cnt, err_cnt);
        end
`endif
    endtask

    task automatic test_wrap_saturation();
        int pulses = 0;
        drive(1, 0, 0);
        drive(0, 1, 0);
        for (int w = 0; w < 300; w++) begin
            for (int v = 15; v >= 0; v--) begin
                drive(0, 1, v);
                if (wrap_pulse === 1'b1) pulses++;
                if (v == 15) begin
                    checks++;
                    if (wrap_pulse !== 1'b1) begin
                        failures++;
                        $display("FAIL sat_pulse wrap=%0d wrap_pulse=%0b exp=1", w, wrap_pulse);
                    end
                end
            end
        end
        checks++;
        if (pulses != 300 || wrap_cnt !== 8'd255) begin
            failures++;
            $display("FAIL sat_total pulses=%0d wrap_cnt=%0d exp=300/255", pulses, wrap_cnt);
        end
    endtask

    task automatic test_clr_priority();
        drive(0, 1, 4);
        drive(0, 1, 9);
        drive(1, 1, 3);
        checks++;
        if (locked !== 1'b0 || last_cnt !== 4'd0 || wrap_cnt !== 8'd0 ||
            err_cnt !== 4'd0 || seq_err !== 1'b0) begin
            failures++;
            $display("FAIL clr_state locked=%0b last=%0d wrap=%0d err=%0d seq_err=%0b exp=all0",
                     locked, last_cnt, wrap_cnt, err_cnt, seq_err);
        end
        drive(0, 1, 11);
        checks++;
        if (locked !== 1'b1 || last_cnt !== 4'd11 || seq_err !== 1'b0 || err_cnt !== 4'd0) begin
            failures++;
            $display("FAIL clr_recapture locked=%0b last=%0d seq_err=%0b err=%0d exp=1/11/0/0",
                     locked, last_cnt, seq_err, err_cnt);
        end
    endtask

    task automatic test_async_reset();
        drive(1, 0, 0);
        drive(0, 1, 1);
        drive(0, 1, 0);
        drive(0, 1, 15);
        drive(0, 1, 14);
        drive(0, 1, 7);
        @(negedge clk);
        clk_en = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({locked, last_cnt, wrap_pulse, wrap_cnt, seq_err, err_cnt} !== 19'd0) begin
            failures++;
            $display("FAIL async_rst got=%0h exp=0",
                     {locked, last_cnt, wrap_pulse, wrap_cnt, seq_err, err_cnt});
        end
        model_reset();
        cnt_vld = 1'b0;
        clr = 1'b0;
        #3;
        rst = 1'b1;
        #2;
        clk_en = 1'b1;
        drive(0, 1, 12);
        checks++;
        if (locked !== 1'b1 || last_cnt !== 4'd12 || seq_err !== 1'b0 || err_cnt !== 4'd0) begin
            failures++;
            $display("FAIL async_capture locked=%0b last=%0d seq_err=%0b err=%0d exp=1/12/0/0",
                     locked, last_cnt, seq_err, err_cnt);
        end
    endtask

    task automatic test_err_saturation();
        drive(1, 0, 0);
        drive(0, 1, 5);
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 5);
`ifdef DCM_ERR_LATCH_EN
            checks++;
            if (seq_err !== 1'b1 || err_cnt !== 4'd1) begin
                failures++;
                $display("FAIL errsat_latched i=%0d seq_err=%0b err=%0d exp=1/1", i, seq_err, err_cnt);
            end
`else
            checks++;
            if (seq_err !== 1'b1) begin
                failures++;
                $display("FAIL errsat_pulse i=%0d seq_err=%0b exp=1", i, seq_err);
            end
`endif
        end
`ifndef DCM_ERR_LATCH_EN
        checks++;
        if (err_cnt !== 4'd15) begin
            failures++;
            $display("FAIL errsat_total err_cnt=%0d exp=15", err_cnt);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit c, v;
            int x;
            c = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 3) != 0);
            x = ($urandom_range(0, 9) < 8) ? (m_last + 15) % 16 : int'($urandom_range(0, 15));
            drive(c, v, x);
            checks++;
            if (locked !== (m_has_ref && !m_fault) || last_cnt !== 4'(m_last) ||
                wrap_pulse !== m_wrap_pulse || seq_err !== m_seq_err ||
                wrap_cnt !== 8'(m_wraps) || err_cnt !== 4'(m_errs)) begin
                failures++;
                $display("FAIL rand i=%0d got l=%0b last=%0d wp=%0b se=%0b wc=%0d ec=%0d exp l=%0b last=%0d wp=%0b se=%0b wc=%0d ec=%0d",
                         i, locked, last_cnt, wrap_pulse, seq_err, wrap_cnt, err_cnt,
                         m_has_ref && !m_fault, m_last, m_wrap_pulse, m_seq_err, m_wraps, m_errs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_mismatch();
        test_wrap_saturation();
        test_clr_priority();
        test_async_reset();
        test_err_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
